udp_loop_sched: RTL and testbench
=================================

Name: udp_loop_sched

Overview:
- Packet-level scheduler for the UDP loopback path between the eth_rmii UDP receive/transmit interface and the single-clock byte FIFO (fifo_2048_d8).
- Gates FIFO writes per packet and admits only packets that fit, dropping the rest whole.
- Keeps a queue of committed packet lengths and launches one UDP transmit per queued packet when the transmitter is idle.
- Guarantees that FIFO read and write byte counts stay packet-aligned, including on truncated or aborted transfers.

Parameters:
- DATA_DEPTH, 2048, byte capacity of the external data FIFO.
- LQ_DEPTH, 8, entries in the internal length queue (power of 2).
- IFG_CYCLES, 16, idle rmii_clk cycles enforced after each transmit before the next udp_txstart.
- START_TIMEOUT, 1024, cycles to wait for udp_txbusy to rise after udp_txstart.

Ports:
- rmii_clk  in  1  clock.
- sys_rst_n  in  1  reset.
- udp_rxstart  in  1  one-cycle pulse, start of received UDP payload; udp_rxamount valid this cycle.
- udp_rxamount  in  16  announced payload byte count.
- udp_rxdv  in  1  received payload byte valid.
- udp_rxend  in  1  one-cycle pulse, end of received payload.
- udp_txbusy  in  1  transmitter busy.
- udp_txreq  in  1  transmitter requests the next payload byte.
- fifo_wrreq  out  1  data FIFO write enable.
- fifo_rdreq  out  1  data FIFO read enable.
- udp_txstart  out  1  one-cycle transmit launch pulse.
- udp_txamount  out  16  transmit byte count; held stable from udp_txstart until the next launch.
- pkt_drop  out  1  one-cycle pulse on packet rejection.
- drop_cnt  out  16  saturating count of dropped packets.
- pkt_pending  out  4  committed packets not yet launched (0..LQ_DEPTH).

Behaviour:
- Clock is rmii_clk. Reset is sys_rst_n, asynchronous, active-low.
- Reset values: all outputs 0. Length queue emptied. Occupancy counter 0. RX FSM in RX_IDLE, TX FSM in TX_IDLE.
- Occupancy counter occ (12 bits, range 0..DATA_DEPTH):
  - +1 on fifo_wrreq alone; -1 on fifo_rdreq alone; unchanged when both are asserted.
- RX FSM, states RX_IDLE, RX_ACCEPT, RX_DROP:
  - On udp_rxstart, the packet is admitted when udp_rxamount != 0, udp_rxamount <= DATA_DEPTH - occ, and the length queue is not full (counting a push due the same cycle).
  - Admitted: go to RX_ACCEPT and clear the written counter wcnt.
  - Otherwise: go to RX_DROP, pulse pkt_drop the next cycle, and increment drop_cnt (saturates at 16'hFFFF).
  - fifo_wrreq = udp_rxdv && state==RX_ACCEPT && wcnt < announced amount. This is combinational from udp_rxdv, zero latency. Bytes beyond the announced amount are discarded.
  - On udp_rxend in RX_ACCEPT: if wcnt (including any byte written the same cycle) > 0, push wcnt to the length queue; then go to RX_IDLE. A zero-byte packet pushes nothing.
  - On udp_rxend in RX_DROP: go to RX_IDLE.
  - udp_rxstart arriving in RX_ACCEPT or RX_DROP without a preceding udp_rxend: close the current packet as if udp_rxend had occurred (push if wcnt > 0), then evaluate admission of the new packet in the same cycle.
  - udp_rxstart and udp_rxend in the same cycle: udp_rxend applies to the old packet first, then udp_rxstart.
- TX FSM, states TX_IDLE, TX_START, TX_WAIT, TX_SEND, TX_FLUSH, TX_GAP:
  - TX_IDLE: when the length queue is not empty and udp_txbusy == 0, pop the head into rem and udp_txamount, then go to TX_START.
  - TX_START: assert udp_txstart for exactly one cycle, then go to TX_WAIT.
  - TX_WAIT:
    - udp_txbusy == 1: go to TX_SEND.
    - START_TIMEOUT cycles without udp_txbusy: go to TX_FLUSH.
    - udp_txreq is honoured in TX_WAIT as in TX_SEND.
  - TX_SEND: fifo_rdreq = udp_txreq && rem != 0, combinational. Each read decrements rem. When udp_txbusy falls: go to TX_GAP if rem == 0, else to TX_FLUSH.
  - TX_FLUSH: assert fifo_rdreq every cycle until rem == 0, then go to TX_GAP. This discards unread bytes to keep the FIFO aligned.
  - TX_GAP: wait IFG_CYCLES cycles, then go to TX_IDLE.
- Length queue push and pop in the same cycle are both honoured. pkt_pending = entries in the queue, registered.
- Push to a full queue cannot occur because admission prevents it.
- Reset mid-packet clears all state. The data FIFO is cleared by the same reset.

Test Plan:
- Single 18-byte packet: udp_rxstart with amount 18, then 18 udp_rxdv bytes, then udp_rxend -> 18 fifo_wrreq; pkt_pending reaches 1; one udp_txstart with udp_txamount = 18; exactly 18 fifo_rdreq; occ returns to 0.
- Back-to-back: three packets of 100, 1, 1472 bytes received while udp_txbusy is held 1 -> pkt_pending = 3. Release busy -> three launches in order with amounts 100, 1, 1472. Gap between consecutive udp_txstart pulses is at least IFG_CYCLES + 2.
- Overflow: occ = 1500, incoming amount 600 -> pkt_drop pulses once; drop_cnt = 1; no fifo_wrreq for those bytes; occ stays 1500. Next 548-byte packet is admitted.
- Truncation: amount 10 with 14 udp_rxdv bytes -> 10 writes, push 10. Amount 10 with 6 bytes then udp_rxend -> push 6 and udp_txamount = 6.
- Transmit abort: udp_txbusy falls after 4 of 20 reads -> TX_FLUSH issues 16 consecutive fifo_rdreq; the next packet's first byte is read correctly.
- Queue full: LQ_DEPTH packets pending -> the next udp_rxstart is dropped. Asynchronous reset mid-TX_SEND -> all outputs 0 within the same cycle, pkt_pending = 0.

Source files
------------

// File: rtl/udp_loop_sched.sv
// Packet scheduler for the UDP loopback path: admits whole packets into the byte FIFO,
// queues their committed lengths and launches one UDP transmit per queued packet.
module udp_loop_sched #(
  parameter int DATA_DEPTH    = 2048,
  parameter int LQ_DEPTH      = 8,
  parameter int IFG_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic        rmii_clk,
  input  logic        sys_rst_n,
  input  logic        udp_rxstart,
  input  logic [15:0] udp_rxamount,
  input  logic        udp_rxdv,
  input  logic        udp_rxend,
  input  logic        udp_txbusy,
  input  logic        udp_txreq,
  output logic        fifo_wrreq,
  output logic        fifo_rdreq,
  output logic        udp_txstart,
  output logic [15:0] udp_txamount,
  output logic        pkt_drop,
  output logic [15:0] drop_cnt,
  output logic [3:0]  pkt_pending
);

  localparam int OCC_W   = $clog2(DATA_DEPTH + 1);
  localparam int PTR_W   = $clog2(LQ_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (START_TIMEOUT > IFG_CYCLES) ? START_TIMEOUT : IFG_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LQ_FULL  = CNT_W'(LQ_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_ACCEPT, RX_DROP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_WAIT, TX_SEND, TX_FLUSH, TX_GAP} tx_state_t;

  rx_state_t        rx_st;
  tx_state_t        tx_st;
  logic [OCC_W-1:0] occ;
  logic [15:0]      wcnt;
  logic [15:0]      rx_amt;
  logic [15:0]      rem;
  logic [TMR_W-1:0] tmr;

  logic [15:0]      lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0] lq_wp;
  logic [PTR_W-1:0] lq_rp;
  logic [CNT_W-1:0] lq_count;

  logic [15:0] wcnt_inc;
  logic [15:0] free_bytes;
  logic [15:0] rem_next;
  logic        lq_push;
  logic        lq_pop;
  logic        lq_full;
  logic        admit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fifo_wrreq = udp_rxdv && (rx_st == RX_ACCEPT) && (wcnt < rx_amt);
    wcnt_inc   = wcnt + 16'(fifo_wrreq);
    // Closing a packet happens on rxend or on an rxstart that arrives without one.
    lq_push    = (rx_st == RX_ACCEPT) && (udp_rxend || udp_rxstart) && (wcnt_inc != 16'd0);
    lq_full    = (lq_count + CNT_W'(lq_push)) >= LQ_FULL;
    // A byte written this very cycle is already spoken for, so it is charged conservatively.
    free_bytes = 16'(DATA_DEPTH) - 16'(occ) - 16'(fifo_wrreq);
    admit      = (udp_rxamount != 16'd0) && (udp_rxamount <= free_bytes) && !lq_full;

    fifo_rdreq = 1'b0;
    case (tx_st)
      TX_WAIT, TX_SEND: fifo_rdreq = udp_txreq && (rem != 16'd0);
      TX_FLUSH:         fifo_rdreq = (rem != 16'd0);
      default:          fifo_rdreq = 1'b0;
    endcase
    rem_next = rem - 16'(fifo_rdreq);
    lq_pop   = (tx_st == TX_IDLE) && (lq_count != '0) && !udp_txbusy;
  end

  assign pkt_pending = 4'(lq_count);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      occ <= '0;
    end else begin
      case ({fifo_wrreq, fifo_rdreq})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_st    <= RX_IDLE;
      wcnt     <= '0;
      rx_amt   <= '0;
      pkt_drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pkt_drop <= 1'b0;
      if (fifo_wrreq) wcnt <= wcnt_inc;
      if (udp_rxstart) begin
        if (admit) begin
          rx_st  <= RX_ACCEPT;
          wcnt   <= '0;
          rx_amt <= udp_rxamount;
        end else begin
          rx_st    <= RX_DROP;
          pkt_drop <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (udp_rxend) begin
        rx_st <= RX_IDLE;
      end
    end
  end

  // NOTE: the length storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge rmii_clk) begin
    if (lq_push) lq_mem[lq_wp] <= wcnt_inc;
  end

  always_ff @(posedge rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lq_wp    <= '0;
      lq_rp    <= '0;
      lq_count <= '0;
    end else begin
      if (lq_push) lq_wp <= lq_wp + PTR_W'(1);
      if (lq_pop)  lq_rp <= lq_rp + PTR_W'(1);
      lq_count <= lq_count + CNT_W'(lq_push) - CNT_W'(lq_pop);
    end
  end

  always_ff @(posedge rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_st        <= TX_IDLE;
      rem          <= '0;
      tmr          <= '0;
      udp_txstart  <= 1'b0;
      udp_txamount <= '0;
    end else begin
      udp_txstart <= 1'b0;
      rem         <= rem_next;
      case (tx_st)
        TX_IDLE: begin
          if (lq_pop) begin
            rem          <= lq_mem[lq_rp];
            udp_txamount <= lq_mem[lq_rp];
            udp_txstart  <= 1'b1;
            tx_st        <= TX_START;
          end
        end
        TX_START: begin
          tmr   <= '0;
          tx_st <= TX_WAIT;
        end
        TX_WAIT: begin
          if (udp_txbusy)           tx_st <= TX_SEND;
          else if (tmr == TMO_LAST) tx_st <= TX_FLUSH;
          else                      tmr   <= tmr + TMR_W'(1);
        end
        TX_SEND: begin
          // A transmitter that quits early leaves bytes behind; flush them to stay aligned.
          if (!udp_txbusy) begin
            tmr   <= '0;
            tx_st <= (rem_next == 16'd0) ? TX_GAP : TX_FLUSH;
          end
        end
        TX_FLUSH: begin
          if (rem_next == 16'd0) begin
            tmr   <= '0;
            tx_st <= TX_GAP;
          end
        end
        TX_GAP: begin
          if (tmr == IFG_LAST) tx_st <= TX_IDLE;
          else                 tmr   <= tmr + TMR_W'(1);
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_loop_sched.sv
// Directed bench for udp_loop_sched: a small transmitter responder, a byte-FIFO model
// and a launch recorder feed hand-computed expectations through check().
module tb_udp_loop_sched;

  logic        rmii_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        udp_rxstart, udp_rxdv, udp_rxend, udp_txbusy, udp_txreq;
  logic [15:0] udp_rxamount;
  logic        fifo_wrreq, fifo_rdreq, udp_txstart, pkt_drop;
  logic [15:0] udp_txamount, drop_cnt;
  logic [3:0]  pkt_pending;

  udp_loop_sched dut (
    .rmii_clk     (rmii_clk),
    .sys_rst_n    (sys_rst_n),
    .udp_rxstart  (udp_rxstart),
    .udp_rxamount (udp_rxamount),
    .udp_rxdv     (udp_rxdv),
    .udp_rxend    (udp_rxend),
    .udp_txbusy   (udp_txbusy),
    .udp_txreq    (udp_txreq),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_rdreq   (fifo_rdreq),
    .udp_txstart  (udp_txstart),
    .udp_txamount (udp_txamount),
    .pkt_drop     (pkt_drop),
    .drop_cnt     (drop_cnt),
    .pkt_pending  (pkt_pending)
  );

  always #5 rmii_clk = ~rmii_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus state
  logic [7:0] rx_byte = 8'h00;
  bit         hold_busy = 1'b0;
  int         abort_idx = -1;
  int         abort_after = 0;

  // Monitor state: byte FIFO model and per-launch records
  logic [7:0] byte_q[$];
  int launch_amt[$], launch_cyc[$], launch_first[$], launch_reads[$], launch_flush[$];
  int wr_total = 0, rd_total = 0, drop_pulses = 0, cyc = 0;

  always @(negedge rmii_clk) begin
    if (!sys_rst_n) begin
      byte_q.delete();
    end else begin
      cyc++;
      if (fifo_wrreq) begin
        byte_q.push_back(rx_byte);
        wr_total++;
      end
      if (fifo_rdreq) begin
        int b;
        int idx;
        b = -1;
        if (byte_q.size() != 0) b = int'(byte_q.pop_front());
        rd_total++;
        if (launch_amt.size() != 0) begin
          idx = launch_amt.size() - 1;
          if (launch_reads[idx] == 0) launch_first[idx] = b;
          launch_reads[idx]++;
          if (!udp_txreq) launch_flush[idx]++;
        end
      end
      if (udp_txstart) begin
        launch_amt.push_back(int'(udp_txamount));
        launch_cyc.push_back(cyc);
        launch_first.push_back(-1);
        launch_reads.push_back(0);
        launch_flush.push_back(0);
      end
      if (pkt_drop) drop_pulses++;
    end
  end

  function automatic int lget(input int sel, input int i);
    if (i < 0 || i >= launch_amt.size()) return -1;
    case (sel)
      0:       return launch_amt[i];
      1:       return launch_first[i];
      2:       return launch_reads[i];
      3:       return launch_flush[i];
      default: return launch_cyc[i];
    endcase
  endfunction

  // Transmitter responder: busy two cycles after udp_txstart, one request per cycle.
  int r_state = 0, r_reqs = 0, r_limit = 0, r_seen = 0;

  initial begin
    udp_txbusy = 1'b0;
    udp_txreq  = 1'b0;
    forever begin
      @(posedge rmii_clk); #1;
      if (!sys_rst_n) begin
        udp_txbusy = 1'b0;
        udp_txreq  = 1'b0;
        r_state    = 0;
      end else begin
        case (r_state)
          0: begin
            udp_txreq  = 1'b0;
            udp_txbusy = hold_busy;
            if (udp_txstart) begin
              r_limit = (r_seen == abort_idx) ? abort_after : int'(udp_txamount);
              r_seen++;
              r_state = 1;
            end
          end
          1: begin
            udp_txbusy = 1'b1;
            udp_txreq  = 1'b1;
            r_reqs     = 1;
            r_state    = 2;
          end
          default: begin
            if (r_reqs >= r_limit) begin
              udp_txbusy = 1'b0;
              udp_txreq  = 1'b0;
              r_state    = 0;
            end else begin
              udp_txreq = 1'b1;
              r_reqs++;
            end
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge rmii_clk); #1;
  endtask

  task automatic send_pkt(input int amount, input int nbytes, input logic [7:0] tag);
    udp_rxstart  = 1'b1;
    udp_rxamount = 16'(amount);
    step();
    udp_rxstart = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      udp_rxdv = 1'b1;
      rx_byte  = 8'(int'(tag) + i);
      step();
    end
    udp_rxdv  = 1'b0;
    udp_rxend = 1'b1;
    step();
    udp_rxend = 1'b0;
  endtask

  task automatic hold();
    hold_busy = 1'b1;
    step();
    step();
  endtask

  task automatic release_and_drain(input int budget);
    bit done;
    done = 1'b0;
    hold_busy = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (pkt_pending == 4'd0 && r_state == 0 && int'(dut.tx_st) == 0) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  int n0, w0, d0;

  initial begin
    udp_rxstart  = 1'b0;
    udp_rxamount = 16'd0;
    udp_rxdv     = 1'b0;
    udp_rxend    = 1'b0;
    repeat (3) step();
    check("rst_wrreq",   32'(fifo_wrreq),   32'd0);
    check("rst_rdreq",   32'(fifo_rdreq),   32'd0);
    check("rst_txstart", 32'(udp_txstart),  32'd0);
    check("rst_txamt",   32'(udp_txamount), 32'd0);
    check("rst_drop",    32'(pkt_drop),     32'd0);
    check("rst_dropcnt", 32'(drop_cnt),     32'd0);
    check("rst_pending", 32'(pkt_pending),  32'd0);
    sys_rst_n = 1'b1;
    step();

    // Single 18-byte packet
    hold();
    w0 = wr_total;
    send_pkt(18, 18, 8'h10);
    check("p1_wr", 32'(wr_total - w0), 32'd18);
    check("p1_pending", 32'(pkt_pending), 32'd1);
    n0 = launch_amt.size();
    release_and_drain(200);
    check("p1_launches", 32'(launch_amt.size() - n0), 32'd1);
    check("p1_amt",   32'(lget(0, n0)), 32'd18);
    check("p1_reads", 32'(lget(2, n0)), 32'd18);
    check("p1_first", 32'(lget(1, n0)), 32'h10);
    check("p1_occ",   32'(dut.occ), 32'd0);

    // Back-to-back 100, 1, 1472 while the transmitter is busy
    hold();
    send_pkt(100, 100, 8'h20);
    send_pkt(1, 1, 8'h30);
    send_pkt(1472, 1472, 8'h40);
    check("b2b_pending", 32'(pkt_pending), 32'd3);
    n0 = launch_amt.size();
    release_and_drain(5000);
    check("b2b_amt0", 32'(lget(0, n0)),     32'd100);
    check("b2b_amt1", 32'(lget(0, n0 + 1)), 32'd1);
    check("b2b_amt2", 32'(lget(0, n0 + 2)), 32'd1472);
    check("b2b_first1", 32'(lget(1, n0 + 1)), 32'h30);
    check("b2b_first2", 32'(lget(1, n0 + 2)), 32'h40);
    check("b2b_reads2", 32'(lget(2, n0 + 2)), 32'd1472);
    check("b2b_gap01", 32'((lget(4, n0 + 1) - lget(4, n0)) >= 18), 32'd1);
    check("b2b_gap12", 32'((lget(4, n0 + 2) - lget(4, n0 + 1)) >= 18), 32'd1);

    // Overflow: occ 1500, 600 dropped, 548 fits exactly
    hold();
    send_pkt(1500, 1500, 8'h50);
    check("ovf_occ1500", 32'(dut.occ), 32'd1500);
    w0 = wr_total;
    d0 = drop_pulses;
    send_pkt(600, 600, 8'h55);
    check("ovf_pulses", 32'(drop_pulses - d0), 32'd1);
    check("ovf_dropcnt", 32'(drop_cnt), 32'd1);
    check("ovf_nowr", 32'(wr_total - w0), 32'd0);
    check("ovf_occ_kept", 32'(dut.occ), 32'd1500);
    send_pkt(548, 548, 8'h60);
    check("ovf_pending", 32'(pkt_pending), 32'd2);
    check("ovf_occ_full", 32'(dut.occ), 32'd2048);
    n0 = launch_amt.size();
    release_and_drain(6000);
    check("ovf_amt0", 32'(lget(0, n0)),     32'd1500);
    check("ovf_amt1", 32'(lget(0, n0 + 1)), 32'd548);
    check("ovf_first1", 32'(lget(1, n0 + 1)), 32'h60);

    // Truncation: surplus bytes discarded, short packet commits what arrived
    hold();
    w0 = wr_total;
    send_pkt(10, 14, 8'h70);
    check("trunc_wr_long", 32'(wr_total - w0), 32'd10);
    w0 = wr_total;
    send_pkt(10, 6, 8'h80);
    check("trunc_wr_short", 32'(wr_total - w0), 32'd6);
    n0 = launch_amt.size();
    release_and_drain(300);
    check("trunc_amt0", 32'(lget(0, n0)),     32'd10);
    check("trunc_amt1", 32'(lget(0, n0 + 1)), 32'd6);
    check("trunc_reads1", 32'(lget(2, n0 + 1)), 32'd6);
    check("trunc_first1", 32'(lget(1, n0 + 1)), 32'h80);

    // Transmit abort after 4 of 20 reads
    hold();
    send_pkt(20, 20, 8'h90);
    send_pkt(5, 5, 8'hA0);
    n0 = launch_amt.size();
    abort_idx   = n0;
    abort_after = 4;
    release_and_drain(400);
    check("abort_reads", 32'(lget(2, n0)), 32'd20);
    check("abort_flush", 32'(lget(3, n0)), 32'd16);
    check("abort_next_amt",   32'(lget(0, n0 + 1)), 32'd5);
    check("abort_next_first", 32'(lget(1, n0 + 1)), 32'hA0);
    check("abort_next_reads", 32'(lget(2, n0 + 1)), 32'd5);
    check("abort_occ", 32'(dut.occ), 32'd0);

    // Queue full, then asynchronous reset mid-transmit
    hold();
    for (int i = 0; i < 8; i++) send_pkt(2, 2, 8'(8'hB0 + 2 * i));
    check("qfull_pending", 32'(pkt_pending), 32'd8);
    send_pkt(2, 2, 8'hC0);
    check("qfull_dropcnt", 32'(drop_cnt), 32'd2);
    check("qfull_pending_kept", 32'(pkt_pending), 32'd8);
    check("qfull_pulses", 32'(drop_pulses), 32'd2);
    hold_busy = 1'b0;
    for (int i = 0; i < 100 && int'(dut.tx_st) != 3; i++) step();
    check("reached_send", 32'(int'(dut.tx_st)), 32'd3);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_wrreq",   32'(fifo_wrreq),   32'd0);
    check("arst_rdreq",   32'(fifo_rdreq),   32'd0);
    check("arst_txstart", 32'(udp_txstart),  32'd0);
    check("arst_txamt",   32'(udp_txamount), 32'd0);
    check("arst_drop",    32'(pkt_drop),     32'd0);
    check("arst_dropcnt", 32'(drop_cnt),     32'd0);
    check("arst_pending", 32'(pkt_pending),  32'd0);
    check("arst_occ",     32'(dut.occ),      32'd0);
    step();
    sys_rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
